// File: rtl/load_store_unit.sv
// Data-memory initiator for the single-cycle CPU: B/H/W loads with extension, sub-word stores as read-modify-write.
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W accesses return resp_err instead of being force-aligned.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  // Handshake: a request is accepted on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE and the requester holds req_valid until then.
  // resp_valid is a single-cycle pulse; resp_rdata/resp_err are meaningful while it is high.

  logic [1:0]        state_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merged_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              funct3_ok;
  logic              misalign;
  logic              req_illegal;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_ext;
  logic [31:0]       merged;
  logic [ADDR_W-1:0] word_addr;

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign dbg_state  = state_q;
  assign word_addr  = {addr_q[ADDR_W-1:2], 2'b00};

  always_comb begin
    funct3_ok = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: funct3_ok = 1'b1;
      default:                                funct3_ok = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  // Lane selection ignores the low bits a half/word cannot use, which force-aligns it.
  assign misalign = 1'b0;
`endif

  assign req_illegal = !funct3_ok || (req_we && req_funct3[2]) || misalign;

  always_comb begin
    byte_sel = 8'h00;
    case (addr_q[1:0])
      2'd0: byte_sel = mem_read_data[7:0];
      2'd1: byte_sel = mem_read_data[15:8];
      2'd2: byte_sel = mem_read_data[23:16];
      default: byte_sel = mem_read_data[31:24];
    endcase
    half_sel = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    load_ext = 32'h0;
    case (f3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_ext = mem_read_data;
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = 32'h0;
    endcase
  end

  always_comb begin
    merged = mem_read_data;
    if (f3_q[1:0] == 2'b00) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      f3_q     <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      merged_q <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (req_illegal) begin
              state_q <= S_RESP;
              err_q   <= 1'b1;
              rdata_q <= 32'h0;
            end else begin
              state_q <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (!we_q) begin
            rdata_q <= load_ext;
            err_q   <= 1'b0;
            state_q <= S_RESP;
          end else if (f3_q[1:0] == 2'b10) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            state_q <= S_RESP;
          end else begin
            merged_q <= merged;
            state_q  <= S_WRITE;
          end
        end
        S_WRITE: begin
          rdata_q <= 32'h0;
          err_q   <= 1'b0;
          state_q <= S_RESP;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    mem_address    = '0;
    mem_write_data = 32'h0;
    case (state_q)
      S_ACCESS: begin
        mem_address = word_addr;
        if (we_q && (f3_q[1:0] == 2'b10)) begin
          mem_write_en   = 1'b1;
          mem_write_data = wdata_q;
        end else begin
          mem_read_en = 1'b1;
        end
      end
      S_WRITE: begin
        mem_address    = word_addr;
        mem_write_en   = 1'b1;
        mem_write_data = merged_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed table-driven bench for load_store_unit with a word-addressed memory model.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic [1:0]  dbg_state;

  logic [31:0] mem [0:63];
  logic [31:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t vecs[14];

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address[7:2]];
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_address[7:2]] <= mem_write_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata,
                              input logic exp_err, input int lat, input int rd, input int wr);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    v.exp_lat = lat; v.exp_rd = rd; v.exp_wr = wr;
    return v;
  endfunction

  // driver: issue one request, monitor until the response pulse, score it
  task automatic do_req(input vec_t v, input string name);
    int lat, rd_cnt, wr_cnt, both_cnt, ready_busy, addr_bad, first_rd, first_wr;
    logic got;
    logic [31:0] exp_rdata;
    logic [31:0] held;
    @(negedge clk);
    check({name, "_ready_before"}, {31'h0, req_ready}, 32'h1);
    req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    req_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(v.exp_rdata);
    #1 req_valid = 1'b0;
    lat = 0; rd_cnt = 0; wr_cnt = 0; both_cnt = 0; ready_busy = 0; addr_bad = 0;
    first_rd = 0; first_wr = 0; got = 1'b0;
    for (int c = 1; c <= 10 && !got; c++) begin
      @(negedge clk);
      if (mem_read_en) begin rd_cnt++; if (first_rd == 0) first_rd = c; end
      if (mem_write_en) begin wr_cnt++; if (first_wr == 0) first_wr = c; end
      if (mem_read_en && mem_write_en) both_cnt++;
      if ((mem_read_en || mem_write_en) && mem_address != (v.addr & 32'hFFFF_FFFC)) addr_bad++;
      if (resp_valid) begin
        got = 1'b1;
        lat = c;
        exp_rdata = exp_q.pop_front();
        check({name, "_rdata"}, resp_rdata, exp_rdata);
        check({name, "_err"}, {31'h0, resp_err}, {31'h0, v.exp_err});
      end else if (req_ready) begin
        ready_busy++;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no resp_valid within 10 cycles", name);
      exp_q.delete();
      return;
    end
    check({name, "_latency"}, lat, v.exp_lat);
    check({name, "_rd_cycles"}, rd_cnt, v.exp_rd);
    check({name, "_wr_cycles"}, wr_cnt, v.exp_wr);
    check({name, "_rd_wr_overlap"}, both_cnt, 0);
    check({name, "_ready_busy"}, ready_busy, 0);
    check({name, "_mem_addr"}, addr_bad, 0);
    if (v.exp_rd == 1 && v.exp_wr == 1) begin
      check({name, "_rd_cycle"}, first_rd, 1);
      check({name, "_wr_cycle"}, first_wr, 2);
    end
    held = resp_rdata;
    @(negedge clk);
    check({name, "_resp_pulse"}, {31'h0, resp_valid}, 32'h0);
    check({name, "_rdata_hold"}, resp_rdata, v.exp_rdata);
    if (held !== resp_rdata) ;
  endtask

  initial begin
    int resp_seen;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check("rst_mem_en", {30'h0, mem_read_en, mem_write_en}, 32'h0);
    check("rst_mem_addr", mem_address, 32'h0);
    check("rst_mem_wdata", mem_write_data, 32'h0);
    rst_n = 1'b1;

    //               we    f3      addr         wdata         rdata         err   lat rd wr
    vecs[0]  = mk(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1);
    vecs[1]  = mk(1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 0);
    vecs[2]  = mk(1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, 2, 1, 0);
    vecs[3]  = mk(1'b0, 3'b100, 32'h12, 32'h0,        32'h000000AD, 1'b0, 2, 1, 0);
    vecs[4]  = mk(1'b0, 3'b001, 32'h10, 32'h0,        32'hFFFFBEEF, 1'b0, 2, 1, 0);
    vecs[5]  = mk(1'b0, 3'b101, 32'h12, 32'h0,        32'h0000DEAD, 1'b0, 2, 1, 0);
    vecs[6]  = mk(1'b1, 3'b000, 32'h11, 32'hFFFFFF55, 32'h0,        1'b0, 3, 1, 1);
    vecs[7]  = mk(1'b0, 3'b010, 32'h10, 32'h0,        32'hDEAD55EF, 1'b0, 2, 1, 0);
    vecs[8]  = mk(1'b1, 3'b001, 32'h12, 32'hFFFF1234, 32'h0,        1'b0, 3, 1, 1);
    vecs[9]  = mk(1'b0, 3'b010, 32'h10, 32'h0,        32'h123455EF, 1'b0, 2, 1, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[10] = mk(1'b0, 3'b010, 32'h12, 32'h0,        32'h0,        1'b1, 1, 0, 0);
`else
    vecs[10] = mk(1'b0, 3'b010, 32'h12, 32'h0,        32'h123455EF, 1'b0, 2, 1, 0);
`endif
    vecs[11] = mk(1'b0, 3'b011, 32'h10, 32'h0,        32'h0,        1'b1, 1, 0, 0);
    vecs[12] = mk(1'b1, 3'b100, 32'h10, 32'h77,       32'h0,        1'b1, 1, 0, 0);
    vecs[13] = mk(1'b0, 3'b010, 32'h10, 32'h0,        32'h123455EF, 1'b0, 2, 1, 0);

    for (int i = 0; i < 14; i++) do_req(vecs[i], $sformatf("vec%0d", i));

    // SB interrupted by reset while in WRITE: no write, no response
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'hAA;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort_access_rd", {31'h0, mem_read_en}, 32'h1);
    @(negedge clk);
    check("abort_write_en", {31'h0, mem_write_en}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort_en_drop", {30'h0, mem_read_en, mem_write_en}, 32'h0);
    check("abort_ready", {31'h0, req_ready}, 32'h1);
    check("abort_state", {30'h0, dbg_state}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_ready_after", {31'h0, req_ready}, 32'h1);
    resp_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid) resp_seen++;
    end
    check("abort_no_resp", resp_seen, 0);
    do_req(mk(1'b0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 1'b0, 2, 1, 0), "abort_lw");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
